mod_mul_shift_add: RTL and testbench

// - Bit-serial modular multiplier: result = (a * b) mod m on WIDTH-bit unsigned operands.
// - Serves as the multiply engine of the fast-power (square-and-multiply) controller, which

---
 rtl/modmath_pkg.sv | 16 +
 rtl/mod_cond_sub.sv | 23 ++
 rtl/mod_mul_shift_add.sv | 116 +++++++++++
 tb/tb_mod_mul_shift_add.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/modmath_pkg.sv
// Shared definitions for the modular-arithmetic engines.
// Holds the default operand width, the multiplier FSM state encoding and the
// bit-counter width derived from the default width.
package modmath_pkg;

    localparam int WIDTH_DEF = 260;
    localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        MUL    = 2'd2,
        FINISH = 2'd3
    } mm_state_t;

endpackage

// File: rtl/mod_cond_sub.sv
// Conditional subtract: y = (x >= m) ? x - m : x, for x < 2m.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
// Ports: x_i (WIDTH+1 bits), m_i (modulus, WIDTH bits), y_o (WIDTH bits).
module mod_cond_sub #(
    parameter int WIDTH = modmath_pkg::WIDTH_DEF
) (
    input  logic [WIDTH:0]   x_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] y_o
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] diff;

    assign m_ext = {1'b0, m_i};
    assign diff  = x_i - m_ext;

    // Callers guarantee x < 2m, so either branch fits in WIDTH bits.
    // With m == 0 the value is truncated; the parent masks that case anyway.
    assign y_o = (x_i >= m_ext) ? WIDTH'(diff) : WIDTH'(x_i);

endmodule

// File: rtl/mod_mul_shift_add.sv
// Bit-serial modular multiplier: result = (a * b) mod m, start/done handshake.
// Latency: done rises exactly 2*WIDTH+1 edges after the edge that samples start.
// Backpressure: start is ignored while busy; done high means idle with result valid.
// Ports: clk, reset (sync, active-high), start, a, b, m (WIDTH-bit operands),
//        result (registered, held until next completion), done.
module mod_mul_shift_add
    import modmath_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    localparam int            CW    = $clog2(WIDTH);
    localparam logic [CW-1:0] I_TOP = CW'(WIDTH - 1);

    mm_state_t        state_q;
    logic [CW-1:0]    i_q;
    logic [WIDTH-1:0] a_q, b_q, m_q, r_q;
    logic [WIDTH-1:0] result_q;
    logic             done_q;

    // Next-value candidates for r, one per datapath step.
    logic [WIDTH-1:0] red_d;   // REDUCE: shift in next bit of a, reduce
    logic [WIDTH-1:0] dbl_d;   // MUL: 2r mod m
    logic [WIDTH-1:0] add_d;   // MUL: (2r mod m + a) mod m
    logic [WIDTH:0]   add_sum;

    mod_cond_sub #(.WIDTH(WIDTH)) u_red (
        .x_i ({r_q, a_q[i_q]}),
        .m_i (m_q),
        .y_o (red_d)
    );

    mod_cond_sub #(.WIDTH(WIDTH)) u_dbl (
        .x_i ({r_q, 1'b0}),
        .m_i (m_q),
        .y_o (dbl_d)
    );

    // a_q < m_q after REDUCE and dbl_d < m_q, so the sum stays below 2m.
    assign add_sum = {1'b0, dbl_d} + {1'b0, a_q};

    mod_cond_sub #(.WIDTH(WIDTH)) u_add (
        .x_i (add_sum),
        .m_i (m_q),
        .y_o (add_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            i_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            r_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        done_q  <= 1'b0;
                        a_q     <= a;
                        b_q     <= b;
                        m_q     <= m;
                        r_q     <= '0;
                        i_q     <= I_TOP;
                        state_q <= REDUCE;
                    end else begin
                        done_q  <= 1'b1;
                    end
                end
                REDUCE: begin
                    // Operand a may exceed m; fold it into [0, m) first.
                    if (i_q == '0) begin
                        a_q     <= red_d;
                        r_q     <= '0;
                        i_q     <= I_TOP;
                        state_q <= MUL;
                    end else begin
                        r_q     <= red_d;
                        i_q     <= i_q - 1'b1;
                    end
                end
                MUL: begin
                    r_q <= b_q[i_q] ? add_d : dbl_d;
                    if (i_q == '0) begin
                        state_q <= FINISH;
                    end else begin
                        i_q     <= i_q - 1'b1;
                    end
                end
                FINISH: begin
                    // With m == 0 the datapath runs but its value is meaningless.
                    result_q <= (m_q == '0) ? '0 : r_q;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mod_mul_shift_add.sv
module tb_mod_mul_shift_add;

    localparam int W      = 260;
    localparam int LAT    = 2 * W + 1;
    localparam int BUDGET = 700;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b, m;
    logic [W-1:0] result;
    logic         done;

    int checks = 0;
    int errors = 0;

    mod_mul_shift_add #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .m      (m),
        .result (result),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain wide arithmetic on the full 2W-bit product.
    function automatic logic [W-1:0] ref_mod(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] mm);
        logic [2*W-1:0] p;
        logic [2*W-1:0] q;
        if (mm == '0) return '0;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        q = p % {{W{1'b0}}, mm};
        return W'(q);
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < (W + 31) / 32; k++) v = (v << 32) | W'($urandom);
        return v;
    endfunction

    task automatic check(input logic [W-1:0] obs, input logic [W-1:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Wait for done, counting edges since the start edge; returns edge count.
    task automatic wait_done(output int cyc, input int poke);
        cyc = 0;
        while (done !== 1'b1 && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
            if (poke != 0) begin
                start = (cyc == poke);
                if (cyc == poke) begin
                    a = rnd(); b = rnd(); m = rnd();
                end
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] im, input int poke, input string tag);
        logic [W-1:0] expv;
        int cyc;
        expv = ref_mod(ia, ib, im);
        @(negedge clk);
        a = ia; b = ib; m = im; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Inputs are free to change once sampled.
        a = rnd(); b = rnd(); m = rnd();
        check(W'(done), W'(0), {tag, "_busy"});
        wait_done(cyc, poke);
        check(W'(cyc), W'(LAT), {tag, "_lat"});
        check(result, expv, {tag, "_res"});
    endtask

    initial begin
        logic [W-1:0] m259, ra, rb, rm, r2a, r2b, r2m;
        int cyc;

        reset = 1'b1; start = 1'b0; a = '0; b = '0; m = '0;
        repeat (3) @(posedge clk);
        #1;
        check(W'(done), W'(0), "rst_done");
        check(result, '0, "rst_result");
        reset = 1'b0;
        @(posedge clk); #1;
        check(W'(done), W'(1), "idle_done");

        run_op(W'(7), W'(5), W'(11), 0, "basic");
        run_op(W'(100), W'(3), W'(7), 0, "a_ge_m");
        run_op(W'(0), W'(123), W'(97), 0, "a_zero");
        run_op(W'(77), W'(0), W'(97), 0, "b_zero");

        m259 = '0;
        m259[258:0] = '1;
        run_op(m259 - W'(1), m259 - W'(1), m259, 0, "big_m1");
        run_op('1, '1, m259, 0, "big_ones");
        run_op(W'(5), W'(6), W'(0), 0, "m_zero");
        run_op(W'(5), W'(6), W'(1), 0, "m_one");

        for (int n = 0; n < 5; n++) begin
            ra = rnd(); rb = rnd();
            rm = rnd() >> $urandom_range(0, W - 2);
            run_op(ra, rb, rm, 0, $sformatf("rand%0d", n));
        end

        // Start pulse while busy must be ignored.
        run_op(W'(123456789), W'(987654321), W'(1000003), 10, "poke_busy");

        // Start held high across completion: back-to-back runs, one-cycle done.
        ra = rnd(); rb = rnd(); rm = rnd() >> 3;
        r2a = rnd(); r2b = rnd(); r2m = rnd() >> 100;
        @(negedge clk);
        a = ra; b = rb; m = rm; start = 1'b1;
        @(posedge clk); #1;
        a = r2a; b = r2b; m = r2m;
        wait_done(cyc, 0);
        check(W'(cyc), W'(LAT), "hold_lat1");
        check(result, ref_mod(ra, rb, rm), "hold_res1");
        @(posedge clk); #1;
        check(W'(done), W'(0), "hold_pulse");
        start = 1'b0;
        a = rnd(); b = rnd(); m = rnd();
        wait_done(cyc, 0);
        check(W'(cyc), W'(LAT), "hold_lat2");
        check(result, ref_mod(r2a, r2b, r2m), "hold_res2");

        // Reset mid-operation clears everything.
        @(negedge clk);
        a = W'(9); b = W'(9); m = W'(50); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (199) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check(result, '0, "midrst_result");
        check(W'(done), W'(0), "midrst_done");
        reset = 1'b0;
        @(posedge clk); #1;
        check(W'(done), W'(1), "midrst_idle");
        run_op(W'(13), W'(17), W'(19), 0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
